// File: rtl/mux_n_pipe_if.sv
// Handshake bundle for the pipelined N:1 selector: upstream offer, downstream drain,
// flush and the sticky select-error flag.
interface mux_n_pipe_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_IN)
) ();
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    flush;
  logic                    sel_err;

  modport master (
    output in_data, sel, in_valid, out_ready, flush,
    input  in_ready, out_data, out_valid, sel_err
  );

  modport slave (
    input  in_data, sel, in_valid, out_ready, flush,
    output in_ready, out_data, out_valid, sel_err
  );
endinterface

// File: rtl/mux_n_pipe.sv
// Registered N:1 operand selector with a two-entry skid buffer so in_ready is a flop
// and there is no combinational path from out_ready back to in_ready.
module mux_n_pipe #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      NUM_IN      = 4,
  parameter int unsigned      SEL_W       = $clog2(NUM_IN),
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input logic          clk,
  input logic          reset,
  mux_n_pipe_if.slave  bus
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StTwo   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             sel_err_q, sel_err_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [SEL_W-1:0] sel_w;
  logic [31:0]      sel_ext;
  logic [WIDTH-1:0] sel_val;
  logic             sel_bad;
  logic             accept;
  logic             xfer;

  assign sel_w   = bus.sel;
  assign sel_ext = 32'(sel_w);

  always_comb begin
    sel_val = DEFAULT_VAL;
    sel_bad = (sel_ext >= NUM_IN);
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (sel_ext == i) sel_val = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    skid_d     = skid_q;
    accept     = bus.in_valid & in_ready_q;
    xfer       = out_valid_q & bus.out_ready;
    // An accepted bad select is flagged even if the word is flushed away.
    sel_err_d  = sel_err_q | (accept & sel_bad);

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          out_data_d = sel_val;
          state_d    = StOne;
        end
      end
      StOne: begin
        if (accept && xfer) begin
          out_data_d = sel_val;
        end else if (accept) begin
          skid_d  = sel_val;
          state_d = StTwo;
        end else if (xfer) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (xfer) begin
          out_data_d = skid_q;
          state_d    = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase

    // Flush only empties the pipe; data registers keep their contents.
    if (bus.flush) begin
      state_d    = StEmpty;
      out_data_d = out_data_q;
      skid_d     = skid_q;
    end

    out_valid_d = (state_d != StEmpty);
    in_ready_d  = (state_d != StTwo);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      out_data_q  <= '0;
      skid_q      <= '0;
      sel_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      skid_q      <= skid_d;
      sel_err_q   <= sel_err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Self-checking bench: scoreboard queue filled on accept, drained on transfer, for a
// 3-input instance (DEFAULT_VAL 0xDEAD) plus a 4-input instance for the stream case.
module tb_mux_n_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mux_n_pipe_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) bus ();
  mux_n_pipe_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) bus4 ();

  mux_n_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .DEFAULT_VAL(32'hDEAD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mux_n_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .DEFAULT_VAL(32'h0)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [31:0] exp_q[$];
  logic        m_sel_err = 1'b0;

  function automatic logic [31:0] sel_model(input logic [95:0] d, input logic [1:0] s);
    case (s)
      2'd0:    return d[31:0];
      2'd1:    return d[63:32];
      2'd2:    return d[95:64];
      default: return 32'hDEAD;
    endcase
  endfunction

  // Advance one cycle, updating the scoreboard from what the bench drove.
  task automatic tick();
    bit acc, xfer;
    acc  = bus.in_valid && (exp_q.size() < 2);
    xfer = bus.out_ready && (exp_q.size() > 0);
    if (acc && bus.sel == 2'd3) m_sel_err = 1'b1;
    if (bus.flush) begin
      exp_q.delete();
    end else begin
      if (xfer) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(sel_model(bus.in_data, bus.sel));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.in_data    = '0;  bus.sel  = '0; bus.in_valid  = 1'b0;
    bus.out_ready  = 1'b1; bus.flush = 1'b0;
    bus4.in_data   = '0;  bus4.sel = '0; bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1; bus4.flush = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    n_cmp++;
    if (bus.out_data !== 32'h0 || bus.sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: out_data=%h sel_err=%b want 0/0", bus.out_data, bus.sel_err);
    end
    reset = 1'b0;
    exp_q.delete();
    m_sel_err = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] want [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    bus4.in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus4.sel      = 2'(i);
      bus4.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (bus4.out_data !== want[i] || bus4.out_valid !== 1'b1 || bus4.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream[%0d]: out_data=%h valid=%b ready=%b want %h/1/1",
                 i, bus4.out_data, bus4.out_valid, bus4.in_ready, want[i]);
      end
    end
    bus4.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus4.out_valid !== 1'b0 || bus4.sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_end: out_valid=%b sel_err=%b want 0/0", bus4.out_valid, bus4.sel_err);
    end
  endtask

  task automatic test_out_of_range();
    bus.out_ready = 1'b1;
    bus.in_data   = {32'h3, 32'h2, 32'h1};
    bus.sel       = 2'd3;
    bus.in_valid  = 1'b1;
    tick();
    n_cmp++;
    if (bus.out_data !== 32'hDEAD || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_data: out_data=%h valid=%b want 0000dead/1", bus.out_data, bus.out_valid);
    end
    n_cmp++;
    if (bus.sel_err !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_err: sel_err=%b want 1", bus.sel_err);
    end
    bus.sel = 2'd1;
    tick();
    n_cmp++;
    if (bus.out_data !== 32'h2 || bus.sel_err !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_sticky: out_data=%h sel_err=%b want 00000002/1", bus.out_data, bus.sel_err);
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in_data   = {32'hC, 32'hB, 32'hA};
    bus.in_valid  = 1'b1;
    bus.sel       = 2'd0;
    tick();
    n_cmp++;
    if (bus.out_data !== 32'hA || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_a: out_data=%h in_ready=%b want a/1", bus.out_data, bus.in_ready);
    end
    bus.sel = 2'd1;
    tick();
    n_cmp++;
    if (bus.out_data !== 32'hA || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_b: out_data=%h in_ready=%b valid=%b want a/0/1",
               bus.out_data, bus.in_ready, bus.out_valid);
    end
    bus.sel = 2'd2;
    tick();
    n_cmp++;
    if (bus.out_data !== 32'hA || bus.in_ready !== 1'b0 || exp_q.size() != 2) begin
      n_fail++;
      $display("FAIL bp_c_blocked: out_data=%h in_ready=%b want a/0", bus.out_data, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    tick();
    n_cmp++;
    if (bus.out_data !== 32'hB || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drain_b: out_data=%h valid=%b ready=%b want b/1/1",
               bus.out_data, bus.out_valid, bus.in_ready);
    end
    tick();
    n_cmp++;
    if (bus.out_data !== 32'hC || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drain_c: out_data=%h valid=%b want c/1", bus.out_data, bus.out_valid);
    end
    bus.in_valid = 1'b0;
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_data   = {32'h30, 32'h20, 32'h10};
    bus.in_valid  = 1'b1;
    bus.sel       = 2'd0;
    tick();
    bus.sel = 2'd2;
    tick();
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_two: in_ready=%b want 0", bus.in_ready);
    end
    bus.flush   = 1'b1;
    bus.in_data = {32'h30, 32'h20, 32'h77};
    bus.sel     = 2'd0;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sel_err !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_empty: valid=%b ready=%b sel_err=%b want 0/1/1",
               bus.out_valid, bus.in_ready, bus.sel_err);
    end
    bus.out_ready = 1'b1;
    bus.in_data   = {32'h0, 32'h0, 32'h55};
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_data !== 32'h55 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_next: out_data=%h valid=%b want 55/1", bus.out_data, bus.out_valid);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_alone: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b0;
    bus.in_data   = {32'h3, 32'h2, 32'h1};
    bus.sel       = 2'd3;
    bus.in_valid  = 1'b1;
    tick();
    bus.sel = 2'd0;
    tick();
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.sel_err !== 1'b0 ||
        bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset: valid=%b data=%h sel_err=%b ready=%b want 0/0/0/1",
               bus.out_valid, bus.out_data, bus.sel_err, bus.in_ready);
    end
    exp_q.delete();
    m_sel_err = 1'b0;
    @(negedge clk);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_data   = {32'h0, 32'h99, 32'h0};
    bus.sel       = 2'd1;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_data !== 32'h99 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_after: out_data=%h valid=%b want 99/1", bus.out_data, bus.out_valid);
    end
    tick();
  endtask

  task automatic test_soak();
    bit hold;
    for (int c = 0; c < 10000; c++) begin
      hold = bus.in_valid && (exp_q.size() >= 2);
      if (!hold) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_data  = {$urandom(), $urandom(), $urandom()};
        bus.sel      = 2'($urandom_range(0, 3));
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 31) == 0);
      n_cmp++;
      if (bus.out_valid !== (exp_q.size() > 0) || bus.in_ready !== (exp_q.size() < 2)) begin
        n_fail++;
        if (n_fail < 20)
          $display("FAIL soak_hs[%0d]: valid=%b ready=%b want held=%0d",
                   c, bus.out_valid, bus.in_ready, exp_q.size());
      end
      if (exp_q.size() > 0) begin
        n_cmp++;
        if (bus.out_data !== exp_q[0]) begin
          n_fail++;
          if (n_fail < 20)
            $display("FAIL soak_data[%0d]: out_data=%h want %h", c, bus.out_data, exp_q[0]);
        end
      end
      n_cmp++;
      if (bus.sel_err !== m_sel_err) begin
        n_fail++;
        if (n_fail < 20)
          $display("FAIL soak_err[%0d]: sel_err=%b want %b", c, bus.sel_err, m_sel_err);
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL soak_drain: out_valid=%b left=%0d want 0/0", bus.out_valid, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_stream();
    test_out_of_range();
    test_backpressure();
    test_flush();
    test_mid_reset();
    test_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_n_pipe.md
# mux_n_pipe

Parametrised, pipelined N:1 operand selector for the RISC-V datapath: the registered successor of the 2:1 combinational selector. It chooses one of NUM_IN WIDTH-bit inputs by `sel`, registers the result, and moves it downstream over a valid/ready handshake. A two-entry skid buffer lets the upstream stage see a registered `in_ready`, so no combinational path runs from `out_ready` to `in_ready`. Typical use: the writeback or forwarding select stage between execute and register-file write, where stall and flush must be honoured.

## Interface
- WIDTH, 32: data width in bits.
- NUM_IN, 4: number of inputs, 2..16.
- SEL_W, $clog2(NUM_IN): width of `sel`.
- DEFAULT_VAL, 0: value output when `sel` ≥ NUM_IN.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  NUM_IN*WIDTH  flat input bus; input i occupies bits [i*WIDTH +: WIDTH].
- sel  in  SEL_W  input select, sampled with `in_data` at accept.
- in_valid  in  1  upstream offers data.
- in_ready  out  1  block can accept; driven directly from a register.
- out_data  out  WIDTH  selected, registered word.
- out_valid  out  1  `out_data` holds a valid word.
- out_ready  in  1  downstream accepts.
- flush  in  1  synchronous discard of all held and incoming words.
- sel_err  out  1  sticky flag: an out-of-range `sel` was accepted.

## Operation
- Handshake rules:
  - Accept occurs when `in_valid & in_ready` at a rising edge.
  - Transfer occurs when `out_valid & out_ready` at a rising edge.
  - The upstream holds `in_data` and `sel` stable while `in_valid & !in_ready`.
- Selected value: `in_data[sel]` when `sel < NUM_IN`; otherwise DEFAULT_VAL, and `sel_err` is set at that edge.
- `sel_err` clears only on reset.
- Storage: an output register (OUT) and a skid register (SKID).
- States:
  - EMPTY: nothing held.
  - ONE: OUT valid.
  - TWO: OUT and SKID valid.
- Outputs per state:
  - `out_valid` = (state != EMPTY).
  - `in_ready` = (state != TWO).
- Transitions (A = accept, T = transfer):
  - EMPTY: A → OUT ← sel value, go to ONE; no A → stay EMPTY.
  - ONE: A & T → OUT ← new value, stay ONE. A & !T → SKID ← new value, go to TWO. !A & T → EMPTY. !A & !T → hold.
  - TWO: T → OUT ← SKID, go to ONE. !T → hold. No accept is possible in TWO.
- Flush has priority over all transitions:
  - Next state is EMPTY.
  - Any word accepted in the same cycle is discarded.
  - Data registers keep their contents; `sel_err` is unaffected.
- Words leave in strict acceptance order; none are lost or duplicated.
- Reset (asynchronous, usable mid-operation) forces:
  - state EMPTY, `out_valid` 0, `in_ready` 1;
  - `out_data` 0, SKID 0, `sel_err` 0.
  - Any held words are dropped.
  - The first accept is possible on the first rising edge after `reset` deasserts.

## Timing
- Latency: a word accepted at edge k appears on `out_data` with `out_valid`=1 after edge k, when in EMPTY, or in ONE with a simultaneous transfer.
- A word held behind a stalled OUT appears one edge after the transfer that frees OUT.
- Throughput: one word per cycle while `out_ready`=1.
- After `out_ready` drops, the block absorbs exactly one more word, then `in_ready`=0 from the next cycle.
- `in_ready` returns to 1 the cycle after the transfer that empties SKID.
- All outputs are registered; no combinational path from any input to any output.
- `out_data` is stable while `out_valid & !out_ready`.

## Test plan
- Reset then stream: reset, then NUM_IN=4, `in_data` = {0x44,0x33,0x22,0x11}, `sel` = 0,1,2,3 on four consecutive cycles with `out_ready`=1 → `out_data` = 0x11, 0x22, 0x33, 0x44 on cycles 1–4; `in_ready` stays 1.
- Backpressure: `out_ready`=0 while words A=0xA, B=0xB, C=0xC are offered → A held on `out_data`, B taken into SKID, `in_ready`=0, C not accepted. Raise `out_ready` → outputs A, B, C in order with no gaps after C is accepted.
- Out-of-range select: NUM_IN=3, `sel`=3, DEFAULT_VAL=0xDEAD → `out_data`=0xDEAD. `sel_err` rises after that edge and stays 1 through later valid selects until reset.
- Flush in TWO state with a concurrent offer → next cycle `out_valid`=0, `in_ready`=1; the offered word never appears; the next accepted word 0x55 comes out alone.
- Mid-operation reset: assert `reset` asynchronously between edges while in TWO → `out_valid`=0 and `out_data`=0 immediately, `sel_err`=0. After release, a word accepted with `sel`=1 is output one edge later.
- Random soak: 10k cycles of random `in_valid`, `out_ready`, `sel` and occasional `flush`, checked against a scoreboard → in-order, lossless delivery and `in_ready` never 1 in state TWO.
